// File: rtl/mem_responder_512x32.sv
// rtl/mem_responder_512x32.sv - memory responder: 512x32 array with configurable read/write latency
module mem_responder_512x32 #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  err_conflict,
    output logic                  addr_oob
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    oob_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    conflict_q;
    logic                    addr_oob_q;

    logic [DATA_WIDTH-1:0]   mem_q [0:(1<<ADDR_WIDTH)-1];

    logic                    req_oob;
    logic                    wr_commit;

    assign req_oob   = |addr_in[DATA_WIDTH-1:ADDR_WIDTH];
    // Gated by reset so an aborted write can never reach the array.
    assign wr_commit = !reset && (state_q == WR_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            oob_q      <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            addr_oob_q <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
            addr_oob_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_enable) begin
                        if (mem_read && mem_write) begin
                            conflict_q <= 1'b1;
                            state_q    <= RELEASE;
                        end else if (mem_read || mem_write) begin
                            idx_q   <= addr_in[ADDR_WIDTH-1:0];
                            wdata_q <= wdata;
                            oob_q   <= req_oob;
                            busy_q  <= 1'b1;
                            if (mem_read) begin
                                cnt_q   <= 4'(READ_LATENCY - 1);
                                state_q <= RD_WAIT;
                            end else begin
                                cnt_q   <= 4'(WRITE_LATENCY - 1);
                                state_q <= WR_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q    <= mem_q[idx_q];
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        addr_oob_q <= oob_q;
                        state_q    <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        addr_oob_q <= oob_q;
                        state_q    <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RELEASE: begin
                    // Hold here until the requester drops enable so a held request is served once.
                    if (!mem_enable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata        = rdata_q;
    assign mem_ready    = ready_q;
    assign mem_busy     = busy_q;
    assign err_conflict = conflict_q;
    assign addr_oob     = addr_oob_q;

endmodule

// File: doc/mem_responder_512x32.md
Name: mem_responder_512x32

Overview:
Memory-side responder for the CPU control unit's memory request signals (enable/read/write). It accepts one request from the control unit, latches the address (MAR) and write data (MDR), and performs the access on an internal 512x32 word array after a configurable latency. It returns read data and a one-cycle ready pulse, so the control FSM can stall its T-state on ready instead of assuming fixed timing.

Parameters:
DATA_WIDTH, 32, word width of the array and data ports
ADDR_WIDTH, 9, index width; the array depth is 2**ADDR_WIDTH = 512 words
READ_LATENCY, 2, clocks from request acceptance to read ready; legal range 1..15
WRITE_LATENCY, 1, clocks from request acceptance to write commit and ready; legal range 1..15

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high
mem_enable  in  1  request qualifier from the control unit
mem_read  in  1  read request; valid only with mem_enable
mem_write  in  1  write request; valid only with mem_enable
addr_in  in  DATA_WIDTH  MAR value
wdata  in  DATA_WIDTH  MDR value, used for writes
rdata  out  DATA_WIDTH  registered read data
mem_ready  out  1  one-cycle completion pulse
mem_busy  out  1  high while a request is in flight
err_conflict  out  1  one-cycle pulse: read and write were both asserted
addr_oob  out  1  asserted together with mem_ready when addr_in[DATA_WIDTH-1:ADDR_WIDTH] was nonzero at acceptance

Behaviour:
- Reset, asynchronous and immediate: state goes to IDLE, latency counter clears to 0, and rdata, mem_ready, mem_busy, err_conflict and addr_oob all go to 0. Array contents are not cleared.
- Reset mid-operation aborts the request. A pending write is never committed.
- FSM states:
  - IDLE to RD_WAIT: at a rising edge when mem_enable=1, mem_read=1, mem_write=0.
  - IDLE to WR_WAIT: at a rising edge when mem_enable=1, mem_write=1, mem_read=0.
  - IDLE, mem_enable=1 with mem_read=1 and mem_write=1: no access is performed. err_conflict pulses high for 1 cycle and the FSM goes to RELEASE.
  - IDLE, mem_enable=1 with neither read nor write asserted: ignored, FSM stays in IDLE.
  - mem_enable=0: read and write are ignored in every state.
- On acceptance at edge k, the block latches the address (addr_in[ADDR_WIDTH-1:0]), wdata, and the out-of-range flag. mem_busy goes to 1 after edge k, and the counter loads the latency minus 1.
- RD_WAIT: the counter decrements each edge. At edge k+READ_LATENCY:
  - rdata <= array[latched index]
  - mem_ready=1 and mem_busy=0 for exactly one cycle
  - addr_oob = latched flag
  - FSM goes to RELEASE.
- WR_WAIT: at edge k+WRITE_LATENCY:
  - array[latched index] <= latched wdata
  - mem_ready=1 and mem_busy=0 for one cycle
  - addr_oob = latched flag
  - rdata unchanged
  - FSM goes to RELEASE.
- Out-of-range addresses wrap: only the low ADDR_WIDTH bits index the array. The access still completes, and addr_oob flags it.
- RELEASE: the FSM waits until mem_enable=0, then returns to IDLE. A request held high across several cycles is therefore served exactly once. A single-cycle request pulse passes through RELEASE in one cycle.
- Request inputs that change while in RD_WAIT, WR_WAIT or RELEASE have no effect. Latched values are used.
- Minimum back-to-back spacing: one IDLE cycle between requests.
- rdata holds its last read value until the next read completes. It is 0 after reset.
- mem_ready and err_conflict are never high in the same cycle. mem_busy and mem_ready are never high in the same cycle.

Test Plan:
- Reset, then write with READ_LATENCY=2, WRITE_LATENCY=1: addr 0x00000010, wdata 0xDEADBEEF, 1-cycle request pulse. Required: mem_busy high 1 cycle, then mem_ready pulse 1 cycle after acceptance. Then read addr 0x10: mem_ready exactly 2 edges after acceptance, rdata=0xDEADBEEF.
- Held request: mem_enable and mem_read held high for 6 cycles on addr 0x10. Required: exactly one mem_ready pulse, and no second access until mem_enable drops and re-asserts.
- Conflict: mem_read=mem_write=1 with mem_enable=1, wdata 0x12345678 to addr 0x20. Required: err_conflict 1-cycle pulse, no mem_ready, and a later read of 0x20 returns the prior contents (not 0x12345678).
- Out of range: write 0xCAFEF00D to addr 0x00000205. Required: mem_ready with addr_oob=1. A read of addr 0x005 returns 0xCAFEF00D with addr_oob=0.
- Reset mid-write: assert reset during WR_WAIT with WRITE_LATENCY=3 on addr 0x30 (prior value 0xAAAA5555). Required: all outputs 0 immediately, no mem_ready, and a read of 0x30 returns 0xAAAA5555.
- mem_enable=0 with mem_read=1 for 5 cycles: required mem_busy=0 throughout, no mem_ready, rdata unchanged.
